lfsr_checker: RTL

//  Receive-side companion to the LFSR pattern generator. Takes one NUM_BITS word per valid

---
 rtl/lfsr_checker.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/lfsr_checker.sv
// Receive-side LFSR pattern checker: hunts for a valid seed, synchronises on a run of
// correct predictions, then flywheels its own LFSR and counts mismatched words.
module lfsr_checker #(
    parameter int NUM_BITS    = 8,
    parameter int LOCK_COUNT  = 16,
    parameter int UNLOCK_ERRS = 4,
    parameter int ERR_CNT_W   = 16
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    input  logic                 i_Valid,
    input  logic [NUM_BITS-1:0]  i_Data,
    input  logic                 i_Clr_Count,
    output logic                 o_Locked,
    output logic                 o_Err,
    output logic [ERR_CNT_W-1:0] o_Err_Count
);

    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int EW = $clog2(UNLOCK_ERRS + 1);

    // One-hot bit for a 1-based tap position; 0 means "no tap".
    function automatic logic [31:0] tap_bit(input int t);
        return (t == 0) ? 32'h0 : (32'h1 << (t - 1));
    endfunction

    // XNOR-feedback tap sets giving maximal-length sequences for widths 3..32.
    function automatic logic [31:0] tap_mask(input int n);
        logic [31:0] m;
        case (n)
            3:       m = tap_bit(3)  | tap_bit(2);
            4:       m = tap_bit(4)  | tap_bit(3);
            5:       m = tap_bit(5)  | tap_bit(3);
            6:       m = tap_bit(6)  | tap_bit(5);
            7:       m = tap_bit(7)  | tap_bit(6);
            8:       m = tap_bit(8)  | tap_bit(6)  | tap_bit(5)  | tap_bit(4);
            9:       m = tap_bit(9)  | tap_bit(5);
            10:      m = tap_bit(10) | tap_bit(7);
            11:      m = tap_bit(11) | tap_bit(9);
            12:      m = tap_bit(12) | tap_bit(6)  | tap_bit(4)  | tap_bit(1);
            13:      m = tap_bit(13) | tap_bit(4)  | tap_bit(3)  | tap_bit(1);
            14:      m = tap_bit(14) | tap_bit(5)  | tap_bit(3)  | tap_bit(1);
            15:      m = tap_bit(15) | tap_bit(14);
            16:      m = tap_bit(16) | tap_bit(15) | tap_bit(13) | tap_bit(4);
            17:      m = tap_bit(17) | tap_bit(14);
            18:      m = tap_bit(18) | tap_bit(11);
            19:      m = tap_bit(19) | tap_bit(6)  | tap_bit(2)  | tap_bit(1);
            20:      m = tap_bit(20) | tap_bit(17);
            21:      m = tap_bit(21) | tap_bit(19);
            22:      m = tap_bit(22) | tap_bit(21);
            23:      m = tap_bit(23) | tap_bit(18);
            24:      m = tap_bit(24) | tap_bit(23) | tap_bit(22) | tap_bit(17);
            25:      m = tap_bit(25) | tap_bit(22);
            26:      m = tap_bit(26) | tap_bit(6)  | tap_bit(2)  | tap_bit(1);
            27:      m = tap_bit(27) | tap_bit(5)  | tap_bit(2)  | tap_bit(1);
            28:      m = tap_bit(28) | tap_bit(25);
            29:      m = tap_bit(29) | tap_bit(27);
            30:      m = tap_bit(30) | tap_bit(6)  | tap_bit(4)  | tap_bit(1);
            31:      m = tap_bit(31) | tap_bit(28);
            32:      m = tap_bit(32) | tap_bit(22) | tap_bit(2)  | tap_bit(1);
            default: m = 32'h0;
        endcase
        return m;
    endfunction

    localparam logic [NUM_BITS-1:0] TAPS     = NUM_BITS'(tap_mask(NUM_BITS));
    localparam logic [NUM_BITS-1:0] ALL_ONES = '1;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t                 state_reg, state_next;
    logic [NUM_BITS-1:0]    r_state_reg, r_state_next;
    logic [MW-1:0]          match_cnt_reg, match_cnt_next;
    logic [EW-1:0]          err_run_reg, err_run_next;
    logic                   err_reg, err_next;
    logic [ERR_CNT_W-1:0]   err_count_reg, err_count_next;
    logic [NUM_BITS-1:0]    pred;
    logic [MW-1:0]          match_inc;
    logic [EW-1:0]          err_run_inc;

    // Prediction is a left shift with the XNOR feedback entering at bit 0.
    assign pred[0] = ~(^(r_state_reg & TAPS));
    generate
        for (genvar gi = 1; gi < NUM_BITS; gi++) begin : g_shift
            assign pred[gi] = r_state_reg[gi-1];
        end
    endgenerate

    assign match_inc   = match_cnt_reg + MW'(1);
    assign err_run_inc = err_run_reg + EW'(1);

    always_comb begin
        state_next     = state_reg;
        r_state_next   = r_state_reg;
        match_cnt_next = match_cnt_reg;
        err_run_next   = err_run_reg;
        err_next       = 1'b0;
        err_count_next = err_count_reg;

        if (i_Valid) begin
            case (state_reg)
                HUNT: begin
                    if (i_Data != ALL_ONES) begin
                        r_state_next   = i_Data;
                        match_cnt_next = '0;
                        state_next     = SYNC;
                    end
                end
                SYNC: begin
                    if (i_Data == pred) begin
                        r_state_next   = i_Data;
                        match_cnt_next = match_inc;
                        if (match_inc == MW'(LOCK_COUNT)) begin
                            state_next   = LOCKED;
                            err_run_next = '0;
                        end
                    end else if (i_Data == ALL_ONES) begin
                        state_next = HUNT;
                    end else begin
                        r_state_next   = i_Data;
                        match_cnt_next = '0;
                    end
                end
                LOCKED: begin
                    // Flywheel: the received word never reloads the LFSR once locked.
                    r_state_next = pred;
                    if (i_Data != pred) begin
                        err_next = 1'b1;
                        if (err_count_reg != '1) begin
                            err_count_next = err_count_reg + ERR_CNT_W'(1);
                        end
                        if (err_run_inc == EW'(UNLOCK_ERRS)) begin
                            state_next   = HUNT;
                            err_run_next = '0;
                        end else begin
                            err_run_next = err_run_inc;
                        end
                    end else begin
                        err_run_next = '0;
                    end
                end
                default: state_next = HUNT;
            endcase
        end

        if (i_Clr_Count) begin
            err_count_next = '0;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_reg     <= HUNT;
            r_state_reg   <= '0;
            match_cnt_reg <= '0;
            err_run_reg   <= '0;
            err_reg       <= 1'b0;
            err_count_reg <= '0;
        end else begin
            state_reg     <= state_next;
            r_state_reg   <= r_state_next;
            match_cnt_reg <= match_cnt_next;
            err_run_reg   <= err_run_next;
            err_reg       <= err_next;
            err_count_reg <= err_count_next;
        end
    end

    assign o_Locked    = (state_reg == LOCKED);
    assign o_Err       = err_reg;
    assign o_Err_Count = err_count_reg;

endmodule
